// File: rtl/fir_pkg.sv
// Shared state type and arithmetic helpers for the time-multiplexed FIR core.
// FIR_SAT_EN selects a saturating output reduction; by default the reduction wraps.
package fir_pkg;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_e;

  localparam int RED_W = 64;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Result is sign-extended to RED_W; the caller keeps the low out_w bits.
  function automatic logic signed [RED_W-1:0] reduce_out(input logic signed [RED_W-1:0] v,
                                                         input int out_w);
`ifdef FIR_SAT_EN
    logic signed [RED_W-1:0] hi;
    logic signed [RED_W-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
`else
    return (v <<< (RED_W - out_w)) >>> (RED_W - out_w);
`endif
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Single shared signed multiply-accumulate; clr has priority over en.
module fir_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [COEF_W-1:0] c_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         acc_q;
  logic signed [ACC_W-1:0]         acc_d;

  assign prod = x_i * c_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_core_tdm.sv
// Time-multiplexed FIR core: one MAC reused over TAPS cycles per sample.
// Output reduction saturates when FIR_SAT_EN is defined, otherwise wraps.
//   IDLE | accept coefficient loads or a new sample
//   MAC  | one product per cycle, idx 0..TAPS-1
//   OUT  | result held on m_tdata until m_tready
module fir_core_tdm
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 11,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_coef_load,
  output logic              s_tready,
  output logic [OUT_W-1:0]  m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              busy
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int IDX_W = $clog2(TAPS);

  fir_state_e               state_q;
  logic [IDX_W-1:0]         idx_q;
  logic signed [DATA_W-1:0] x_q    [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic                     m_tvalid_q;
  logic [OUT_W-1:0]         m_tdata_q;
  logic                     busy_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sh;
  logic                     coef_fire;
  logic                     samp_fire;

  assign s_tready  = (state_q == IDLE);
  assign coef_fire = s_tvalid & s_tready & s_coef_load;
  assign samp_fire = s_tvalid & s_tready & ~s_coef_load;
  assign acc_sh    = acc >>> SHIFT;

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (samp_fire),
    .en_i  (state_q == MAC),
    .x_i   (x_q[idx_q]),
    .c_i   (coef_q[idx_q]),
    .acc_o (acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      if (coef_fire) begin
        for (int k = TAPS - 1; k > 0; k--) coef_q[k] <= coef_q[k-1];
        coef_q[0] <= s_tdata[COEF_W-1:0];
      end
      if (samp_fire) begin
        for (int k = TAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
        x_q[0] <= s_tdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (samp_fire) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          // idx stops at TAPS-1; it is rewound only when the next sample arrives
          if (idx_q == IDX_W'(TAPS - 1)) state_q <= OUT;
          else idx_q <= idx_q + IDX_W'(1);
        end
        OUT: begin
          if (!m_tvalid_q) begin
            m_tdata_q  <= OUT_W'(reduce_out(RED_W'(acc_sh), OUT_W));
            m_tvalid_q <= 1'b1;
          end else if (m_tready) begin
            m_tvalid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_fir_core_tdm.sv
// Self-checking bench for fir_core_tdm (TAPS=4) with an OUT_W=18 and an OUT_W=16 instance in lockstep.
module tb_fir_core_tdm;

  localparam int TAPS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_coef_load;
  logic        m_tready;
  logic        s_tready, s16_tready;
  logic [17:0] m_tdata;
  logic [15:0] m16_tdata;
  logic        m_tvalid, m16_tvalid;
  logic        busy, busy16;

  int errors = 0;
  int checks = 0;
  int mc[TAPS];
  int mx[TAPS];

  always #5 clk = ~clk;

  fir_core_tdm #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(18), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_coef_load(s_coef_load), .s_tready(s_tready), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .busy(busy));

  fir_core_tdm #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(16), .SHIFT(0)) dut16 (
    .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_coef_load(s_coef_load), .s_tready(s16_tready), .m_tdata(m16_tdata),
    .m_tvalid(m16_tvalid), .m_tready(m_tready), .busy(busy16));

  // Reference: y = sum coef[k]*x[n-k], then reduce to w bits.
  function automatic longint model_y();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(mc[k]) * longint'(mx[k]);
    return s;
  endfunction

  function automatic longint model_reduce(input longint y, input int w);
    longint m, hi, r;
    m  = longint'(1) << w;
    hi = m / 2 - 1;
`ifdef FIR_SAT_EN
    r = y;
    if (y > hi) r = hi;
    if (y < -(m / 2)) r = -(m / 2);
`else
    r = y % m;
    if (r < 0) r += m;
    if (r > hi) r -= m;
`endif
    return r;
  endfunction

  task automatic idle_inputs();
    s_tvalid = 1'b0; s_coef_load = 1'b0; s_tdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    m_tready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < TAPS; k++) begin mc[k] = 0; mx[k] = 0; end
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string who);
    int n = 0;
    while (s_tready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (s_tready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s: s_tready timeout, got %b required 1", who, s_tready);
    end
  endtask

  task automatic load_coef(input logic [7:0] v);
    wait_ready("load_coef");
    s_tvalid = 1'b1; s_coef_load = 1'b1; s_tdata = v;
    @(posedge clk); #1;
    idle_inputs();
    for (int k = TAPS - 1; k > 0; k--) mc[k] = mc[k-1];
    mc[0] = int'($signed(v));
  endtask

  task automatic send_sample(input logic [7:0] v, output longint y);
    wait_ready("send_sample");
    s_tvalid = 1'b1; s_coef_load = 1'b0; s_tdata = v;
    @(posedge clk); #1;
    idle_inputs();
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = int'($signed(v));
    y = model_y();
  endtask

  // Waits for m_tvalid, captures both outputs, holds m_tready low 'hold' cycles, then transfers.
  task automatic collect(input int hold, output logic [17:0] d18, output logic [15:0] d16,
                         output bit to);
    int n = 0;
    to = 1'b0;
    m_tready = 1'b0;
    while (m_tvalid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (m_tvalid !== 1'b1) begin
      to = 1'b1; d18 = 'x; d16 = 'x;
      return;
    end
    d18 = m_tdata; d16 = m16_tdata;
    repeat (hold) begin @(posedge clk); #1; end
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready: got %b required 1", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b required 0", m_tvalid); end
    checks++; if (m_tdata !== 18'h0) begin errors++; $display("FAIL reset_m_tdata: got %h required 0", m_tdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if ({s16_tready, m16_tvalid, busy16, m16_tdata} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
      errors++; $display("FAIL reset_dut16: got %b%b%b/%h required 100/0000", s16_tready, m16_tvalid, busy16, m16_tdata);
    end
  endtask

  task automatic test_impulse();
    int imp[4]  = '{1, 0, 0, 0};
    int expv[4] = '{1, 2, 3, 4};
    longint y;
    logic [17:0] d18; logic [15:0] d16; bit to;
    do_reset();
    load_coef(8'd4); load_coef(8'd3); load_coef(8'd2); load_coef(8'd1);
    for (int i = 0; i < 4; i++) begin
      send_sample(8'(imp[i]), y);
      collect(0, d18, d16, to);
      checks++;
      if (to) begin errors++; $display("FAIL impulse_%0d: no m_tvalid, required %0d", i, expv[i]); end
      else if (d18 !== 18'(expv[i]) || d18 !== 18'(model_reduce(y, 18)) || d16 !== 16'(model_reduce(y, 16))) begin
        errors++; $display("FAIL impulse_%0d: got %h/%h required %h", i, d18, d16, 18'(expv[i]));
      end
    end
  endtask

  task automatic test_latency();
    longint y;
    int first_valid = -1;
    int low = 0;
    logic [17:0] d = '0;
    wait_ready("latency");
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_coef_load = 1'b0; s_tdata = 8'd3;
    @(posedge clk); #1;
    idle_inputs();
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = 3;
    y = model_y();
    for (int c = 0; c < 20; c++) begin
      if (s_tready === 1'b1) break;
      low++;
      if (m_tvalid === 1'b1 && first_valid < 0) begin first_valid = c; d = m_tdata; end
      @(posedge clk); #1;
    end
    m_tready = 1'b0;
    checks++; if (first_valid != TAPS + 1) begin errors++; $display("FAIL latency_valid: got edge +%0d required +%0d", first_valid, TAPS + 1); end
    checks++; if (low != TAPS + 2) begin errors++; $display("FAIL latency_ready_low: got %0d cycles required %0d", low, TAPS + 2); end
    checks++; if (d !== 18'(model_reduce(y, 18))) begin errors++; $display("FAIL latency_data: got %h required %h", d, 18'(model_reduce(y, 18))); end
  endtask

  task automatic test_backpressure();
    longint y1, y2;
    logic [17:0] d0, d18; logic [15:0] d16; bit to;
    int n = 0;
    logic [7:0] v2;
    v2 = 8'($urandom_range(1, 255));
    m_tready = 1'b0;
    send_sample(8'($urandom_range(0, 255)), y1);
    while (m_tvalid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    d0 = m_tdata;
    checks++; if (m_tvalid !== 1'b1 || d0 !== 18'(model_reduce(y1, 18))) begin
      errors++; $display("FAIL bp_first: got valid=%b data=%h required valid=1 data=%h", m_tvalid, d0, 18'(model_reduce(y1, 18)));
    end
    s_tvalid = 1'b1; s_coef_load = 1'b0; s_tdata = v2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== d0 || s_tready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold_%0d: got valid=%b data=%h ready=%b busy=%b required 1/%h/0/1", i, m_tvalid, m_tdata, s_tready, busy, d0);
      end
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    m_tready = 1'b0;
    checks++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got valid=%b ready=%b required 0/1", m_tvalid, s_tready);
    end
    @(posedge clk); #1;
    idle_inputs();
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = int'($signed(v2));
    y2 = model_y();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_accept_next: got busy=%b required 1", busy); end
    collect(0, d18, d16, to);
    checks++; if (to || d18 !== 18'(model_reduce(y2, 18)) || d16 !== 16'(model_reduce(y2, 16))) begin
      errors++; $display("FAIL bp_next_data: got %h/%h required %h/%h", d18, d16, 18'(model_reduce(y2, 18)), 16'(model_reduce(y2, 16)));
    end
  endtask

  task automatic test_overflow();
    longint y;
    logic [17:0] d18; logic [15:0] d16; bit to;
    logic [15:0] exp16;
`ifdef FIR_SAT_EN
    exp16 = 16'h8000;
`else
    exp16 = 16'h0200;
`endif
    do_reset();
    repeat (4) load_coef(8'd127);
    for (int i = 0; i < 4; i++) begin
      send_sample(8'h80, y);
      collect(0, d18, d16, to);
      checks++; if (to || d18 !== 18'(model_reduce(y, 18)) || d16 !== 16'(model_reduce(y, 16))) begin
        errors++; $display("FAIL overflow_%0d: got %h/%h required %h/%h", i, d18, d16, 18'(model_reduce(y, 18)), 16'(model_reduce(y, 16)));
      end
    end
    checks++; if (d18 !== 18'(-65024) || d16 !== exp16) begin
      errors++; $display("FAIL overflow_final: got %h/%h required %h/%h", d18, d16, 18'(-65024), exp16);
    end
  endtask

  task automatic test_reset_mid_mac();
    longint y;
    logic [17:0] d18; logic [15:0] d16; bit to;
    int seen = 0;
    do_reset();
    load_coef(8'd4); load_coef(8'd3); load_coef(8'd2); load_coef(8'd1);
    send_sample(8'd7, y);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 1'b1) begin
      errors++; $display("FAIL midmac_reset: got valid=%b busy=%b ready=%b required 0/0/1", m_tvalid, busy, s_tready);
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < TAPS; k++) begin mc[k] = 0; mx[k] = 0; end
    m_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (m_tvalid === 1'b1) seen++; end
    m_tready = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL midmac_discard: got %0d valid cycles required 0", seen); end
    send_sample(8'd9, y);
    collect(0, d18, d16, to);
    checks++; if (to || d18 !== 18'h0 || d16 !== 16'h0 || y != 0) begin
      errors++; $display("FAIL midmac_after: got %h/%h required 0", d18, d16);
    end
  endtask

  task automatic test_ignored_load();
    int expv[4] = '{1, 2, 3, 4};
    longint y;
    logic [17:0] d18; logic [15:0] d16; bit to;
    int n = 0;
    do_reset();
    load_coef(8'd4); load_coef(8'd3); load_coef(8'd2); load_coef(8'd1);
    send_sample(8'd1, y);
    s_tvalid = 1'b1; s_coef_load = 1'b1; s_tdata = 8'h55;
    while (m_tvalid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) send_sample(8'd0, y);
      collect(0, d18, d16, to);
      checks++; if (to || d18 !== 18'(expv[i]) || d18 !== 18'(model_reduce(y, 18))) begin
        errors++; $display("FAIL ignored_load_%0d: got %h required %h", i, d18, 18'(expv[i]));
      end
    end
  endtask

  task automatic test_back_to_back_random();
    longint y;
    logic [17:0] d18; logic [15:0] d16; bit to;
    do_reset();
    for (int k = 0; k < TAPS; k++) load_coef(8'($urandom_range(0, 255)));
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) load_coef(8'($urandom_range(0, 255)));
      send_sample(8'($urandom_range(0, 255)), y);
      collect($urandom_range(0, 2), d18, d16, to);
      checks++; if (to || d18 !== 18'(model_reduce(y, 18)) || d16 !== 16'(model_reduce(y, 16))) begin
        errors++; $display("FAIL random_%0d: got %h/%h required %h/%h", i, d18, d16, 18'(model_reduce(y, 18)), 16'(model_reduce(y, 16)));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    m_tready = 1'b0;
    idle_inputs();
    test_reset();
    test_impulse();
    test_latency();
    test_backpressure();
    test_overflow();
    test_reset_mid_mac();
    test_ignored_load();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
